tone_gen: RTL and testbench
===========================

# tone_gen

Downstream of the PS/2 keyboard decoder. Consumes the 8-bit ASCII key code that the decoder (or its record/replay mux) drives and turns it into a square-wave note on a single speaker pin. The incoming code is combinational and glitchy, so it is first qualified by a stability filter. It then selects one of 21 notes (Z–M row = octave 3, A–J row = octave 4, Q–U row = octave 5). A half-period counter generates the tone.

## Interface
- CLK_HZ, 50_000_000, sys_clk frequency; sets every half-period constant
- STABLE_CYCLES, 1000, consecutive identical samples required before a new key code is committed (≥1)
- sys_clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- key_asci  input  8  ASCII key code from keyboard stage; 8'h00 = no key
- spk  output  1  square-wave speaker drive; 0 when silent
- playing  output  1  1 while a valid note is sounding
- note_idx  output  5  0 = silent, 1..21 = C3..B5 in the order listed below

## Operation
- Note map (ASCII → idx, Hz):
  - Octave 3: Z 5A→1 131, X 58→2 147, C 43→3 165, V 56→4 175, B 42→5 196, N 4E→6 220, M 4D→7 247.
  - Octave 4: A 41→8 262, S 53→9 294, D 44→10 330, F 46→11 349, G 47→12 392, H 48→13 440, J 4A→14 494.
  - Octave 5: Q 51→15 523, W 57→16 587, E 45→17 659, R 52→18 698, T 54→19 784, Y 59→20 880, U 55→21 988.
  - Any other code → idx 0.
- Half period HP(idx) = CLK_HZ / (2·Hz), integer division. At 50 MHz: idx1 = 190839, idx13 = 56818, idx21 = 25303. The phase counter is 18 bits; elaboration fails if any HP ≥ 2^18.
- Qualifier:
  - key_asci is registered into key_r every cycle. stab_cnt clears whenever key_asci ≠ key_r, else increments, saturating at STABLE_CYCLES.
  - When stab_cnt reaches STABLE_CYCLES and key_r ≠ committed code, commit key_r and pulse commit for one cycle.
  - Re-presenting the already-committed code never re-commits.
- Tone FSM, states IDLE and PLAY:
  - IDLE: spk=0, playing=0, note_idx=0. A commit with mapped idx → PLAY.
  - PLAY: phase counts 0..HP−1. On reaching HP−1, phase clears and spk toggles.
  - Commit with a different mapped idx → stay in PLAY, load new HP, phase=0, spk=1 (phase restart).
  - Commit with idx 0 (key release, 00, unmapped) → IDLE.
- On entry to PLAY: spk=1, phase=0, note_idx=idx, playing=1.

## Timing
- Reset values: spk=0, playing=0, note_idx=0, committed=8'h00, key_r=8'h00, stab_cnt=0, phase=0, state IDLE.
- Latency: the new code is first sampled at edge 1. The commit pulse is high after edge N+1 (N=STABLE_CYCLES). spk/playing/note_idx change at edge N+2.
- Tone period: exactly 2·HP cycles; high and low phases are each HP cycles.
- A glitch shorter than N cycles never commits; the current note continues with no phase disturbance.
- Key change before N is reached restarts qualification from 0.
- rst asserted mid-note: all outputs are at reset values after that edge. After deassertion, the held key needs a full N+2 cycles to sound again.
- rst has priority over commit in the same cycle.

## Structure
- Package tone_pkg:
  - Note-frequency table (21 Hz constants).
  - Function asci_to_idx (case map above).
  - Function half_period(idx, CLK_HZ).
  - Phase width constant (18).
  - State enum.
- Sub-module key_qualifier holds key_r, stab_cnt and committed, and outputs commit plus committed code. tone_gen holds the index lookup, FSM and phase counter.

## Test plan
- Reset: hold key_asci=48 through rst → spk=0, playing=0, note_idx=0. After release, with N=4, note_idx=13 at edge 6 post-release and spk=1.
- Period check, CLK_HZ=50e6: key H (48) → spk high 56818 cycles, low 56818, repeating; key U (55) → 25303/25303.
- Glitch rejection, N=4: while A (41) plays, drive 53 for 3 cycles then 41 → note_idx stays 8 and spk edges are unchanged.
- Note change A→S: after qualification note_idx=9 and spk restarts high with phase 0. Then key 00 held N cycles → playing=0, spk=0 at edge N+2.
- Unmapped code 31 ('1') held → stays IDLE, note_idx=0.
- Mid-note reset at an arbitrary phase → outputs zero on the next edge, then retrigger after N+2.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants, note tables and helpers for the tone generator.
//   PHASE_W / IDX_W / KEY_W  field widths
//   NOTE_HZ                  pitch of notes 1..21 (C3..B5)
//   asci_to_idx              ASCII key code -> note index (0 = silent)
//   half_period              sys_clk cycles per half tone period
package tone_pkg;

  localparam int unsigned KEY_W     = 8;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned PHASE_W   = 18;
  localparam int unsigned NUM_NOTES = 21;

  localparam int unsigned NOTE_HZ [NUM_NOTES] = '{
    131, 147, 165, 175, 196, 220, 247,
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } tone_state_e;

  // Keyboard rows Z..M, A..J, Q..U map to octaves 3, 4, 5.
  function automatic logic [IDX_W-1:0] asci_to_idx(input logic [KEY_W-1:0] code);
    case (code)
      8'h5A: return 5'd1;
      8'h58: return 5'd2;
      8'h43: return 5'd3;
      8'h56: return 5'd4;
      8'h42: return 5'd5;
      8'h4E: return 5'd6;
      8'h4D: return 5'd7;
      8'h41: return 5'd8;
      8'h53: return 5'd9;
      8'h44: return 5'd10;
      8'h46: return 5'd11;
      8'h47: return 5'd12;
      8'h48: return 5'd13;
      8'h4A: return 5'd14;
      8'h51: return 5'd15;
      8'h57: return 5'd16;
      8'h45: return 5'd17;
      8'h52: return 5'd18;
      8'h54: return 5'd19;
      8'h59: return 5'd20;
      8'h55: return 5'd21;
      default: return 5'd0;
    endcase
  endfunction

  // Elaboration-time only: clk_hz and idx are constants at every call site.
  function automatic int unsigned half_period(input int unsigned idx, input int unsigned clk_hz);
    if (idx == 0 || idx > NUM_NOTES) return 0;
    return clk_hz / (2 * NOTE_HZ[5'(idx - 1)]);
  endfunction

endpackage

// File: rtl/tone_gen_key_qualifier.sv
// Stability filter for the glitchy combinational key code.
//   sys_clk, rst   clock, synchronous active-high reset
//   key_asci       raw key code
//   commit         one-cycle pulse when a new stable code is accepted
//   committed      last accepted code
module key_qualifier
  import tone_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_asci,
  output logic             commit,
  output logic [KEY_W-1:0] committed
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [KEY_W-1:0] key_r;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] stab_cnt_c;
  logic             commit_c;

  // Count consecutive identical samples, saturating at the threshold so a
  // held code commits exactly once.
  always_comb begin
    stab_cnt_c = stab_cnt;
    commit_c   = 1'b0;
    if (key_asci != key_r) begin
      stab_cnt_c = '0;
    end else if (stab_cnt != CNT_W'(STABLE_CYCLES)) begin
      stab_cnt_c = stab_cnt + CNT_W'(1);
    end
    if ((stab_cnt_c == CNT_W'(STABLE_CYCLES)) && (key_r != committed)) begin
      commit_c = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      key_r     <= '0;
      stab_cnt  <= '0;
      committed <= '0;
      commit    <= 1'b0;
    end else begin
      key_r    <= key_asci;
      stab_cnt <= stab_cnt_c;
      commit   <= commit_c;
      if (commit_c) begin
        committed <= key_r;
      end
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Square-wave note generator driven by a qualified ASCII key code.
//   sys_clk, rst   clock, synchronous active-high reset
//   key_asci       ASCII key code, 8'h00 = no key
//   spk            speaker drive, 0 when silent
//   playing        high while a note sounds
//   note_idx       0 = silent, 1..21 = C3..B5
module tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_asci,
  output logic             spk,
  output logic             playing,
  output logic [IDX_W-1:0] note_idx
);

  localparam int unsigned TAB_N = 2 ** IDX_W;

  logic             commit;
  logic [KEY_W-1:0] committed;
  logic [IDX_W-1:0] idx_c;

  key_qualifier #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_key_qualifier (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .key_asci (key_asci),
    .commit   (commit),
    .committed(committed)
  );

  assign idx_c = asci_to_idx(committed);

  // Constant half-period table; entries 0 and 22..31 are unused zeros.
  logic [PHASE_W-1:0] hp_tab [TAB_N];

  for (genvar i = 0; i < TAB_N; i++) begin : g_hp
    localparam int unsigned HP = half_period(i, CLK_HZ);
    if (HP >= 2 ** PHASE_W) begin : g_hp_overflow
      $error("tone_gen: half period of note %0d does not fit the phase counter", i);
    end
    assign hp_tab[i] = PHASE_W'(HP);
  end

  tone_state_e        state;
  tone_state_e        state_c;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_c;
  logic [PHASE_W-1:0] hp_r;
  logic [PHASE_W-1:0] hp_c;
  logic               spk_c;
  logic               playing_c;
  logic [IDX_W-1:0]   note_idx_c;

  // Next-state and next-output logic; a mapped commit always (re)starts
  // the note high with phase 0, an unmapped commit silences it.
  always_comb begin
    state_c    = state;
    phase_c    = phase;
    hp_c       = hp_r;
    spk_c      = spk;
    playing_c  = playing;
    note_idx_c = note_idx;
    case (state)
      ST_IDLE: begin
        if (commit && (idx_c != '0)) begin
          state_c    = ST_PLAY;
          phase_c    = '0;
          hp_c       = hp_tab[idx_c];
          spk_c      = 1'b1;
          playing_c  = 1'b1;
          note_idx_c = idx_c;
        end
      end
      ST_PLAY: begin
        if (commit) begin
          if (idx_c == '0) begin
            state_c    = ST_IDLE;
            phase_c    = '0;
            spk_c      = 1'b0;
            playing_c  = 1'b0;
            note_idx_c = '0;
          end else begin
            phase_c    = '0;
            hp_c       = hp_tab[idx_c];
            spk_c      = 1'b1;
            note_idx_c = idx_c;
          end
        end else if (phase == hp_r - PHASE_W'(1)) begin
          phase_c = '0;
          spk_c   = ~spk;
        end else begin
          phase_c = phase + PHASE_W'(1);
        end
      end
      default: begin
        state_c = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= '0;
      hp_r     <= '0;
      spk      <= 1'b0;
      playing  <= 1'b0;
      note_idx <= '0;
    end else begin
      state    <= state_c;
      phase    <= phase_c;
      hp_r     <= hp_c;
      spk      <= spk_c;
      playing  <= playing_c;
      note_idx <= note_idx_c;
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: directed scenarios plus randomized key
// sequences compared against a behavioural model of notes and timing.
module tb_tone_gen;

  localparam int CLK_HZ  = 20_000;
  localparam int FAST_HZ = 50_000_000;
  localparam int N       = 4;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] key_asci = 8'h00;
  logic       spk;
  logic       playing;
  logic [4:0] note_idx;

  logic       rst_f = 1'b1;
  logic [7:0] key_f = 8'h00;
  logic       spk_f;
  logic       playing_f;
  logic [4:0] note_idx_f;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  tone_gen #(.CLK_HZ(CLK_HZ), .STABLE_CYCLES(N)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .key_asci(key_asci),
    .spk     (spk),
    .playing (playing),
    .note_idx(note_idx)
  );

  tone_gen #(.CLK_HZ(FAST_HZ), .STABLE_CYCLES(N)) dut_fast (
    .sys_clk (sys_clk),
    .rst     (rst_f),
    .key_asci(key_f),
    .spk     (spk_f),
    .playing (playing_f),
    .note_idx(note_idx_f)
  );

  // ---------------- reference model ----------------
  int    hz_tab [21] = '{131, 147, 165, 175, 196, 220, 247,
                         262, 294, 330, 349, 392, 440, 494,
                         523, 587, 659, 698, 784, 880, 988};
  string keys = "ZXCVBNMASDFGHJQWERTYU";

  function automatic int ref_idx(input logic [7:0] k);
    for (int i = 0; i < 21; i++) begin
      if (keys[i] == k) return i + 1;
    end
    return 0;
  endfunction

  function automatic int ref_hp(input int idx, input int clk_hz);
    return clk_hz / (2 * hz_tab[idx - 1]);
  endfunction

  // Sample history as a run (value, length); a note sounds from some edge
  // onward and its level follows from the elapsed edge count.
  int         m_edge = 0;
  logic [7:0] m_run_val = 8'h00;
  int         m_run_len = 1;
  logic [7:0] m_committed = 8'h00;
  bit         m_pend = 1'b0;
  int         m_idx = 0;
  int         m_start = 0;
  int         m_hp = 1;

  task automatic model_edge(input logic r, input logic [7:0] k);
    int ni;
    m_edge++;
    if (r) begin
      m_run_val   = 8'h00;
      m_run_len   = 1;
      m_committed = 8'h00;
      m_pend      = 1'b0;
      m_idx       = 0;
    end else begin
      if (m_pend) begin
        ni = ref_idx(m_committed);
        if (ni != 0) begin
          m_idx   = ni;
          m_start = m_edge;
          m_hp    = ref_hp(ni, CLK_HZ);
        end else begin
          m_idx = 0;
        end
      end
      if (k == m_run_val) begin
        m_run_len++;
      end else begin
        m_run_val = k;
        m_run_len = 1;
      end
      m_pend = (m_run_len == N + 1) && (m_run_val != m_committed);
      if (m_pend) m_committed = m_run_val;
    end
  endtask

  function automatic logic exp_spk();
    if (m_idx == 0) return 1'b0;
    return (((m_edge - m_start) / m_hp) % 2) == 0;
  endfunction

  // Drive one cycle of the main DUT and advance the model.
  task automatic tick(input logic r, input logic [7:0] k);
    rst = r;
    key_asci = k;
    @(posedge sys_clk);
    model_edge(r, k);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'h48);
      checks++;
      if (spk !== 1'b0 || playing !== 1'b0 || note_idx !== 5'd0) begin
        errors++;
        $display("FAIL reset_hold: spk=%b playing=%b note_idx=%0d, want 0/0/0", spk, playing, note_idx);
      end
    end
    for (int i = 1; i <= N + 2; i++) begin
      tick(1'b0, 8'h48);
      checks++;
      if (i < N + 2) begin
        if (playing !== 1'b0 || note_idx !== 5'd0) begin
          errors++;
          $display("FAIL reset_latency edge %0d: playing=%b note_idx=%0d, want 0/0", i, playing, note_idx);
        end
      end else if (note_idx !== 5'd13 || spk !== 1'b1 || playing !== 1'b1) begin
        errors++;
        $display("FAIL reset_first_note: spk=%b playing=%b note_idx=%0d, want 1/1/13", spk, playing, note_idx);
      end
    end
  endtask

  task automatic test_period();
    logic [7:0] codes [3];
    int hp, idx, n, hi, lo;
    codes[0] = 8'h48; codes[1] = 8'h55; codes[2] = 8'h5A;
    for (int t = 0; t < 3; t++) begin
      idx = ref_idx(codes[t]);
      hp  = ref_hp(idx, CLK_HZ);
      for (int i = 0; i < N + 2; i++) tick(1'b0, 8'h00);
      n = 0;
      while (note_idx == 5'd0 && n < 20) begin
        tick(1'b0, codes[t]);
        n++;
      end
      checks++;
      if (note_idx !== 5'(idx) || spk !== 1'b1 || n != N + 2) begin
        errors++;
        $display("FAIL period_start %h: note_idx=%0d spk=%b after %0d edges, want %0d/1 after %0d", codes[t], note_idx, spk, n, idx, N + 2);
      end
      hi = 0;
      do begin hi++; tick(1'b0, codes[t]); end while (spk === 1'b1 && hi < 4 * hp);
      lo = 0;
      do begin lo++; tick(1'b0, codes[t]); end while (spk === 1'b0 && lo < 4 * hp);
      checks++;
      if (hi != hp || lo != hp) begin
        errors++;
        $display("FAIL period %h: high=%0d low=%0d cycles, want %0d/%0d", codes[t], hi, lo, hp, hp);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < N + 2; i++) tick(1'b0, 8'h00);
    for (int i = 0; i < N + 2; i++) tick(1'b0, 8'h41);
    checks++;
    if (note_idx !== 5'd8 || spk !== 1'b1) begin
      errors++;
      $display("FAIL glitch_setup: note_idx=%0d spk=%b, want 8/1", note_idx, spk);
    end
    for (int i = 0; i < 56; i++) begin
      tick(1'b0, (i >= 10 && i < 10 + N - 1) ? 8'h53 : 8'h41);
      checks++;
      if (note_idx !== 5'd8 || spk !== exp_spk()) begin
        errors++;
        $display("FAIL glitch cycle %0d: note_idx=%0d spk=%b, want 8/%b", i, note_idx, spk, exp_spk());
      end
    end
  endtask

  task automatic test_change();
    int hp;
    hp = ref_hp(ref_idx(8'h53), CLK_HZ);
    for (int i = 1; i <= N + 2; i++) begin
      tick(1'b0, 8'h53);
      checks++;
      if (i < N + 2 && note_idx !== 5'd8) begin
        errors++;
        $display("FAIL change_hold edge %0d: note_idx=%0d, want 8", i, note_idx);
      end else if (i == N + 2 && (note_idx !== 5'd9 || spk !== 1'b1)) begin
        errors++;
        $display("FAIL change_new: note_idx=%0d spk=%b, want 9/1", note_idx, spk);
      end
    end
    for (int j = 1; j <= hp; j++) begin
      tick(1'b0, 8'h53);
      checks++;
      if (spk !== (j < hp)) begin
        errors++;
        $display("FAIL change_phase edge %0d: spk=%b, want %b", j, spk, (j < hp));
      end
    end
    for (int i = 1; i <= N + 2; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (i < N + 2 && playing !== 1'b1) begin
        errors++;
        $display("FAIL release_hold edge %0d: playing=%b, want 1", i, playing);
      end else if (i == N + 2 && (playing !== 1'b0 || spk !== 1'b0 || note_idx !== 5'd0)) begin
        errors++;
        $display("FAIL release: playing=%b spk=%b note_idx=%0d, want 0/0/0", playing, spk, note_idx);
      end
    end
  endtask

  task automatic test_unmapped();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 8'h31);
      checks++;
      if (note_idx !== 5'd0 || playing !== 1'b0 || spk !== 1'b0) begin
        errors++;
        $display("FAIL unmapped cycle %0d: note_idx=%0d playing=%b spk=%b, want 0/0/0", i, note_idx, playing, spk);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n, wait_n;
    n = 0;
    while (playing !== 1'b1 && n < 20) begin
      tick(1'b0, 8'h59);
      n++;
    end
    wait_n = $urandom_range(3, 60);
    for (int i = 0; i < wait_n; i++) tick(1'b0, 8'h59);
    checks++;
    if (note_idx !== 5'd20 || spk !== exp_spk()) begin
      errors++;
      $display("FAIL midreset_setup: note_idx=%0d spk=%b, want 20/%b", note_idx, spk, exp_spk());
    end
    tick(1'b1, 8'h59);
    checks++;
    if (spk !== 1'b0 || playing !== 1'b0 || note_idx !== 5'd0) begin
      errors++;
      $display("FAIL midreset: spk=%b playing=%b note_idx=%0d, want 0/0/0", spk, playing, note_idx);
    end
    for (int i = 1; i <= N + 2; i++) begin
      tick(1'b0, 8'h59);
      checks++;
      if (i < N + 2 && note_idx !== 5'd0) begin
        errors++;
        $display("FAIL midreset_wait edge %0d: note_idx=%0d, want 0", i, note_idx);
      end else if (i == N + 2 && (note_idx !== 5'd20 || spk !== 1'b1 || playing !== 1'b1)) begin
        errors++;
        $display("FAIL midreset_retrigger: note_idx=%0d spk=%b playing=%b, want 20/1/1", note_idx, spk, playing);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] code;
    int sel, hold;
    logic r;
    for (int s = 0; s < 300; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       code = keys[$urandom_range(0, 20)];
      else if (sel == 7) code = 8'h00;
      else if (sel == 8) code = 8'h31;
      else               code = 8'($urandom_range(0, 255));
      hold = $urandom_range(1, 10);
      for (int h = 0; h < hold; h++) begin
        r = ($urandom_range(0, 59) == 0);
        tick(r, code);
        checks++;
        if (spk !== exp_spk() || playing !== (m_idx != 0) || note_idx !== 5'(m_idx)) begin
          errors++;
          $display("FAIL random seg %0d key %h: spk=%b playing=%b note_idx=%0d, want %b/%b/%0d",
                   s, code, spk, playing, note_idx, exp_spk(), (m_idx != 0), m_idx);
        end
      end
    end
  endtask

  task automatic test_fast();
    int hp, n, hi, lo;
    hp = ref_hp(21, FAST_HZ);
    rst_f = 1'b0;
    key_f = 8'h55;
    n = 0;
    while (note_idx_f == 5'd0 && n < 20) begin
      tick(1'b0, 8'h00);
      n++;
    end
    checks++;
    if (note_idx_f !== 5'd21 || spk_f !== 1'b1 || playing_f !== 1'b1) begin
      errors++;
      $display("FAIL fast_start: note_idx=%0d spk=%b playing=%b, want 21/1/1", note_idx_f, spk_f, playing_f);
    end
    hi = 0;
    do begin hi++; tick(1'b0, 8'h00); end while (spk_f === 1'b1 && hi < hp + 100);
    lo = 0;
    do begin lo++; tick(1'b0, 8'h00); end while (spk_f === 1'b0 && lo < hp + 100);
    checks++;
    if (hi != hp || lo != hp) begin
      errors++;
      $display("FAIL fast_period U: high=%0d low=%0d cycles, want %0d/%0d", hi, lo, hp, hp);
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_glitch();
    test_change();
    test_unmapped();
    test_mid_reset();
    test_random();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
